// File: rtl/fft_pkg.sv
// Shared FFT constants, RAM word layout and scheduler state encoding.
// Compile-time option for the scheduler: FFT_SCHED_BITREV_EN.
package fft_pkg;

   localparam int LOG2N = 12;
   localparam int N     = 1 << LOG2N;

   typedef struct packed {
      logic signed [15:0] re;   // [31:16]
      logic signed [15:0] im;   // [15:0]
   } word_t;

   typedef enum logic [2:0] {
      IDLE,
      BITREV,
      STAGE,
      DRAIN,
      DONE
   } state_t;

   // Largest i with i < bitrev(i): top pairs of bits mirror as ones, the
   // innermost pair is 0/1, everything else is one.
   function automatic int last_swap(input int log2n);
      return ((1 << log2n) - 1) - (1 << ((log2n + 1) / 2));
   endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational W-bit reversal, shared by the scheduler and the datapath.
// Latency: 0 cycles. Backpressure: none (pure logic).
module fft_bitrev #(
   parameter int W = 12
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   for (genvar j = 0; j < W; j++) begin : g_rev
      assign dout[j] = din[W-1-j];
   end

endmodule

// File: rtl/fft_sched.sv
// Radix-2 FFT op scheduler: optional bit-reverse swap pass (FFT_SCHED_BITREV_EN), then LOG2N butterfly stages.
// Latency: first op valid the cycle after start is accepted, then 1 op/cycle.
// Backpressure: op_valid/op_ready handshake; op_valid drops while MAX_OUT ops await wb_done.
module fft_sched #(
   parameter int LOG2N   = fft_pkg::LOG2N,
   parameter int MAX_OUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             op_swap,
   output logic [LOG2N-1:0] op_addr_a,
   output logic [LOG2N-1:0] op_addr_b,
   output logic [LOG2N-2:0] op_tw_idx,
   output logic [3:0]       op_stage,
   output logic             op_last,
   input  logic             wb_done
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int KW = LOG2N - 1;

   import fft_pkg::*;

   state_t           state, state_nx;
   logic [LOG2N-1:0] idx, idx_nx;
   logic [3:0]       stage, stage_nx;
   logic             from_rev, from_rev_nx;
   logic [CW-1:0]    outst;
   logic             room, xfer;

   // Butterfly addressing: the low s bits of k stay in place, the rest
   // shift up one to open the gap of width half between a and b.
   logic [KW-1:0]    k;
   logic [LOG2N-1:0] kx, half, lomask, bf_a, bf_b;
   logic [KW-1:0]    tw;
   logic [3:0]       twsh;

   assign k      = idx[KW-1:0];
   assign kx     = {1'b0, k};
   assign half   = LOG2N'(1) << stage;
   assign lomask = ~({LOG2N{1'b1}} << stage);
   assign bf_a   = ((kx & ~lomask) << 1) | (kx & lomask);
   assign bf_b   = bf_a | half;
   assign twsh   = 4'(KW) - stage;
   assign tw     = (k & lomask[KW-1:0]) << twsh;

`ifdef FFT_SCHED_BITREV_EN
   localparam logic [LOG2N-1:0] LAST_SWAP = LOG2N'(last_swap(LOG2N));
   logic [LOG2N-1:0] rev;
   logic             swap_hit;

   fft_bitrev #(.W(LOG2N)) u_rev (
      .din  (idx),
      .dout (rev)
   );

   assign swap_hit = idx < rev;
`endif

   assign room = outst != CW'(MAX_OUT);
   assign xfer = op_valid & op_ready;
   assign busy = (state == BITREV) || (state == STAGE) || (state == DRAIN);
   assign done = state == DONE;

   // Op presentation is a pure function of held state, so a stalled op
   // stays put until the handshake completes.
   always_comb begin
      op_valid  = 1'b0;
      op_swap   = 1'b0;
      op_addr_a = '0;
      op_addr_b = '0;
      op_tw_idx = '0;
      op_stage  = '0;
      op_last   = 1'b0;
      if (state == STAGE && room) begin
         op_valid  = 1'b1;
         op_addr_a = bf_a;
         op_addr_b = bf_b;
         op_tw_idx = tw;
         op_stage  = stage;
         op_last   = k == '1;
      end
`ifdef FFT_SCHED_BITREV_EN
      if (state == BITREV && room && swap_hit) begin
         op_valid  = 1'b1;
         op_swap   = 1'b1;
         op_addr_a = idx;
         op_addr_b = rev;
         op_last   = idx == LAST_SWAP;
      end
`endif
   end

   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      stage_nx    = stage;
      from_rev_nx = from_rev;
      case (state)
         IDLE: begin
            if (start) begin
               stage_nx    = '0;
               from_rev_nx = 1'b0;
`ifdef FFT_SCHED_BITREV_EN
               // index 0 never swaps; the accept cycle stands in for its scan slot
               state_nx    = BITREV;
               idx_nx      = LOG2N'(1);
`else
               state_nx    = STAGE;
               idx_nx      = '0;
`endif
            end
         end
`ifdef FFT_SCHED_BITREV_EN
         BITREV: begin
            if (!swap_hit || xfer) begin
               if (idx == '1) begin
                  state_nx    = DRAIN;
                  from_rev_nx = 1'b1;
               end else begin
                  idx_nx = idx + LOG2N'(1);
               end
            end
         end
`endif
         STAGE: begin
            if (xfer) begin
               if (k == '1) begin
                  state_nx = DRAIN;
               end else begin
                  idx_nx = idx + LOG2N'(1);
               end
            end
         end
         DRAIN: begin
            if (outst == '0) begin
               state_nx = STAGE;
               idx_nx   = '0;
               if (from_rev) begin
                  from_rev_nx = 1'b0;
               end else if (stage == 4'(LOG2N - 1)) begin
                  state_nx = DONE;
               end else begin
                  stage_nx = stage + 4'd1;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         stage    <= '0;
         from_rev <= 1'b0;
         outst    <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         stage    <= stage_nx;
         from_rev <= from_rev_nx;
         if (state == IDLE && start) begin
            outst <= '0;
            err   <= 1'b0;
         end else begin
            // a writeback with nothing in flight is flagged, never underflowed
            if (wb_done && outst == '0) begin
               err <= 1'b1;
            end
            case ({xfer, wb_done})
               2'b10:   outst <= outst + CW'(1);
               2'b01:   if (outst != '0) outst <= outst - CW'(1);
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fft_sched.sv
// Bench for fft_sched: expected op stream derived from the FFT indexing rules with plain arithmetic.
module tb_fft_sched;

   localparam int LOG2N   = 12;
   localparam int TW      = LOG2N - 1;
   localparam int N       = 1 << LOG2N;
   localparam int MAX_OUT = 8;
`ifdef FFT_SCHED_BITREV_EN
   localparam int EXP_SWAPS = 2016;
   localparam int START_PHASE = 0;
`else
   localparam int EXP_SWAPS = 0;
   localparam int START_PHASE = 1;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start, busy, done, err, op_valid, op_ready, op_swap, op_last, wb_done;
   logic [LOG2N-1:0] op_addr_a, op_addr_b;
   logic [TW-1:0]    op_tw_idx;
   logic [3:0]       op_stage;

   fft_sched #(.LOG2N(LOG2N), .MAX_OUT(MAX_OUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_swap   (op_swap),
      .op_addr_a (op_addr_a),
      .op_addr_b (op_addr_b),
      .op_tw_idx (op_tw_idx),
      .op_stage  (op_stage),
      .op_last   (op_last),
      .wb_done   (wb_done)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nerr = 0;
   int m_phase, m_i, m_s, m_k, last_sw;
   int bo, ndone, nswap, nbfly, last_stage, ready_mode, cyc;
   bit echo_en, force_wb, prev_stall;
   logic [3:0]  sh;
   logic [40:0] prev_op;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rev_of(input int x);
      int r = 0;
      for (int j = 0; j < LOG2N; j++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   task automatic m_seek();
      while (m_phase == 0 && !(m_i < rev_of(m_i))) begin
         m_i++;
         if (m_i == N) m_phase = 1;
      end
   endtask

   task automatic m_init();
      m_phase = START_PHASE;
      m_i = 0; m_s = 0; m_k = 0;
      m_seek();
   endtask

   task automatic m_adv();
      if (m_phase == 0) begin
         m_i++;
         if (m_i == N) m_phase = 1;
         m_seek();
      end else if (m_phase == 1) begin
         m_k++;
         if (m_k == N / 2) begin
            m_k = 0;
            m_s++;
            if (m_s == LOG2N) m_phase = 2;
         end
      end
   endtask

   function automatic logic [40:0] exp_op();
      int half, a, b, t;
      if (m_phase == 0)
         return {1'b1, LOG2N'(m_i), LOG2N'(rev_of(m_i)), TW'(0), 4'd0, m_i == last_sw};
      if (m_phase == 1) begin
         half = 1 << m_s;
         a = (m_k / half) * 2 * half + m_k % half;
         b = a + half;
         t = (m_k % half) * (1 << (LOG2N - 1 - m_s));
         return {1'b0, LOG2N'(a), LOG2N'(b), TW'(t), 4'(m_s), m_k == N / 2 - 1};
      end
      return '1;
   endfunction

   // One cycle: sample at negedge, then drive inputs for the next posedge.
   task automatic tick();
      logic [40:0] obs;
      bit x;
      @(negedge clk);
      obs = {op_swap, op_addr_a, op_addr_b, op_tw_idx, op_stage, op_last};
      if (done) ndone++;
      if (prev_stall) check("stall_hold", 64'({op_valid, obs}), 64'({1'b1, prev_op}));
      if (bo == MAX_OUT) check("credit_stop", 64'(op_valid), 64'(0));
      case (ready_mode)
         0:       op_ready = 1'b0;
         1:       op_ready = 1'b1;
         default: op_ready = ($urandom_range(3) != 0);
      endcase
      x = op_valid & op_ready;
      if (x) begin
         check("op", 64'(obs), 64'(exp_op()));
         if (m_phase == 1 && m_s == 0 && m_k == 0)
            check("addr_s0k0", 64'({op_addr_a, op_addr_b, op_tw_idx}), 64'({12'd0, 12'd1, 11'd0}));
         if (m_phase == 1 && m_s == 1 && m_k == 3)
            check("addr_s1k3", 64'({op_addr_a, op_addr_b, op_tw_idx}), 64'({12'd5, 12'd7, 11'd1024}));
         if (m_phase == 1 && m_s == 11 && m_k == 5)
            check("addr_s11k5", 64'({op_addr_a, op_addr_b, op_tw_idx}), 64'({12'd5, 12'd2053, 11'd5}));
         if (op_swap) begin
            nswap++;
         end else begin
            if (int'(op_stage) != last_stage) check("no_overlap", 64'(bo), 64'(0));
            last_stage = int'(op_stage);
            nbfly++;
         end
         m_adv();
      end
      prev_stall = op_valid & !op_ready;
      prev_op    = obs;
      sh         = {sh[2:0], x};
      wb_done    = force_wb | (echo_en & sh[3]);
      if (x && !wb_done) bo++;
      else if (!x && wb_done && bo > 0) bo--;
   endtask

   initial begin
      start = 1'b0; op_ready = 1'b0; wb_done = 1'b0;
      ready_mode = 0; echo_en = 1'b0; force_wb = 1'b0; prev_stall = 1'b0;
      sh = '0; bo = 0; ndone = 0; nswap = 0; nbfly = 0; last_stage = -1;
      last_sw = 0;
      for (int i = 0; i < N; i++) if (i < rev_of(i)) last_sw = i;

      repeat (3) @(negedge clk);
      check("reset_state", 64'({busy, done, err, op_valid, op_swap, op_addr_a, op_addr_b,
                                op_tw_idx, op_stage, op_last}), 64'(0));
      reset = 1'b0;
      tick(); tick();

      // spurious writeback while idle
      force_wb = 1'b1; tick(); force_wb = 1'b0; tick();
      check("idle_wb_err", 64'({err, busy}), 64'(2'b10));

      // run B: withheld writebacks, random ready, reset in stage 5
      m_init();
      start = 1'b1; tick(); start = 1'b0;
      check("start_b", 64'({busy, op_valid, err}), 64'(3'b110));
      force_wb = 1'b1; tick(); force_wb = 1'b0; tick();
      check("busy_wb_err", 64'(err), 64'(1));
      ready_mode = 2;
      repeat (100) tick();
      check("stall_at_max", 64'(bo), 64'(MAX_OUT));
      check("valid_low_at_max", 64'(op_valid), 64'(0));
      ready_mode = 0; force_wb = 1'b1;
      while (bo > 0) tick();
      force_wb = 1'b0; tick();
      echo_en = 1'b1; sh = '0; ready_mode = 2; cyc = 0;
      while (!(m_phase == 1 && m_s == 5 && m_k >= 1000) && cyc < 40000) begin
         tick();
         cyc++;
      end
      check("reach_stage5", 64'(m_phase == 1 && m_s == 5), 64'(1));
      reset = 1'b1; op_ready = 1'b0; wb_done = 1'b0;
      @(negedge clk);
      check("reset_mid", 64'({busy, done, err, op_valid, op_swap, op_addr_a, op_addr_b,
                              op_tw_idx, op_stage, op_last}), 64'(0));
      reset = 1'b0;
      bo = 0; sh = '0; prev_stall = 1'b0; echo_en = 1'b0; ready_mode = 1;
      repeat (5) tick();
      check("no_done_b", 64'({ndone, busy}), 64'(0));

      // run A: full transform, ready held, writeback 3 cycles after each transfer
      m_init();
      ndone = 0; nswap = 0; nbfly = 0; last_stage = -1; echo_en = 1'b1; sh = '0; cyc = 0;
      start = 1'b1; tick(); start = 1'b0;
      check("first_lat", 64'({busy, op_valid}), 64'(2'b11));
      while (ndone == 0 && cyc < 60000) begin
         tick();
         cyc++;
      end
      repeat (6) tick();
      check("done_once", 64'(ndone), 64'(1));
      check("swaps", 64'(nswap), 64'(EXP_SWAPS));
      check("butterflies", 64'(nbfly), 64'(24576));
      check("model_end", 64'(m_phase), 64'(2));
      check("end_flags", 64'({busy, err, op_valid}), 64'(0));
      check("end_outstanding", 64'(bo), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
